// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter.
// Holds the FSM state encoding and the default values of the arbiter parameters.
package fifo_arb_pkg;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Round-robin requester selector (purely combinational).
// Ports:
//   req        in  NREQ          request vector
//   last_owner in  clog2(NREQ)   most recent grantee; search starts one past it
//   valid      out 1             at least one request is pending
//   index      out clog2(NREQ)   first requester at or after (last_owner+1) mod NREQ
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_owner,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] index
);

  localparam int OW = $clog2(NREQ);

  int w_k;

  // Walk the ring backwards from the farthest candidate so that the last
  // hit written is the nearest one after last_owner.
  always_comb begin
    valid = 1'b0;
    index = '0;
    w_k   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_k = (int'(last_owner) + 1 + i) % NREQ;
      if (req[w_k]) begin
        valid = 1'b1;
        index = w_k[OW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter feeding a single FIFO write port from NREQ requesters.
// Ports:
//   clk        in  1             rising-edge clock
//   rst_n      in  1             asynchronous active-low reset
//   req        in  NREQ          per-requester write request
//   wdata      in  NREQ*DW       requester i data in bits [i*DW +: DW]
//   last       in  NREQ          per-requester end-of-burst marker
//   ack        out NREQ          one-hot beat-accepted strobe
//   fifo_full  in  1             FIFO full flag
//   fifo_wr    out 1             FIFO write enable
//   fifo_data  out DW            FIFO write data
//   owner      out clog2(NREQ)   current grantee
//   busy       out 1             high while a grant is held
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      wdata,
  input  logic [NREQ-1:0]         last,
  output logic [NREQ-1:0]         ack,
  input  logic                    fifo_full,
  output logic                    fifo_wr,
  output logic [DW-1:0]           fifo_data,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
);

  localparam int OW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t    r_state;
  logic [OW-1:0] r_owner;
  logic [OW-1:0] r_last_owner;
  logic [BW-1:0] r_beat_cnt;

  logic          w_valid;
  logic [OW-1:0] w_index;
  logic          w_req_own;
  logic          w_beat;
  logic          w_burst_end;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req        (req),
    .last_owner (r_last_owner),
    .valid      (w_valid),
    .index      (w_index)
  );

  assign w_req_own   = req[r_owner];
  // The write strobe is combinational from the registered owner so a full
  // FIFO stalls the beat in the same cycle it is flagged.
  assign w_beat      = (r_state == GRANT) && w_req_own && !fifo_full;
  assign w_burst_end = last[r_owner] || (r_beat_cnt == BW'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_owner <= OW'(NREQ - 1);
      r_beat_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state      <= GRANT;
            r_owner      <= w_index;
            r_last_owner <= w_index;
            r_beat_cnt   <= '0;
          end
        end
        GRANT: begin
          if (!w_req_own) begin
            r_state <= IDLE;
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + BW'(1);
            if (w_burst_end) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fifo_wr   = w_beat;
  assign fifo_data = w_beat ? wdata[int'(r_owner)*DW +: DW] : '0;
  assign ack       = w_beat ? (NREQ'(1) << r_owner) : '0;
  assign owner     = r_owner;
  assign busy      = (r_state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arb.sv
module tb_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  last;
  logic [3:0]  ack;
  logic        fifo_full;
  logic        fifo_wr;
  logic [7:0]  fifo_data;
  logic [1:0]  owner;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [31:0] WD = 32'hD3D2D1D0;

  fifo_wr_arb #(.NREQ(4), .DW(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .wdata     (wdata),
    .last      (last),
    .ack       (ack),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_data (fifo_data),
    .owner     (owner),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".wr"},   32'(fifo_wr), 32'd0);
    chk({tag, ".data"}, 32'(fifo_data), 32'd0);
    chk({tag, ".ack"},  32'(ack), 32'd0);
  endtask

  task automatic outs(input string tag, input logic eb, input logic [1:0] eo,
                      input logic ew, input logic [7:0] ed, input logic [3:0] ea);
    chk({tag, ".busy"},  32'(busy), 32'(eb));
    chk({tag, ".owner"}, 32'(owner), 32'(eo));
    chk({tag, ".wr"},    32'(fifo_wr), 32'(ew));
    chk({tag, ".data"},  32'(fifo_data), 32'(ed));
    chk({tag, ".ack"},   32'(ack), 32'(ea));
  endtask

  // Inputs change on the falling edge; checks follow 1 time unit later.
  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic f,
                       input logic [31:0] wd);
    @(negedge clk);
    req = r; last = l; fifo_full = f; wdata = wd;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req = 4'hF; last = 4'h0; fifo_full = 1'b0; wdata = WD;

    // reset: requests present but nothing may be written
    #1;
    idle("rst0");
    chk("rst0.owner", 32'(owner), 32'd0);
    drive(4'hF, 4'h0, 1'b0, WD);
    idle("rst1");
    chk("rst1.owner", 32'(owner), 32'd0);

    // two-beat burst from requester 0 ended by last
    @(negedge clk);
    rst_n = 1'b1; req = 4'b0001; last = 4'h0; wdata = 32'hD3D2D1A1;
    #1;
    idle("t1.c1");
    drive(4'b0001, 4'b0000, 1'b0, 32'hD3D2D1A1);
    outs("t1.c2", 1'b1, 2'd0, 1'b1, 8'hA1, 4'b0001);
    drive(4'b0001, 4'b0001, 1'b0, 32'hD3D2D1A2);
    outs("t1.c3", 1'b1, 2'd0, 1'b1, 8'hA2, 4'b0001);
    drive(4'b0000, 4'b0000, 1'b0, WD);
    idle("t1.c4");

    // fresh reset so requester 0 leads the rotation
    @(negedge clk); rst_n = 1'b0; #1;
    idle("rst2");
    chk("rst2.owner", 32'(owner), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // all requesting, no last: 4-beat bursts, one idle cycle between grants
    for (int g = 0; g < 5; g++) begin
      drive(4'hF, 4'h0, 1'b0, WD);
      idle($sformatf("t2.g%0d.idle", g));
      for (int b = 0; b < 4; b++) begin
        drive(4'hF, 4'h0, 1'b0, WD);
        outs($sformatf("t2.g%0d.b%0d", g, b), 1'b1, 2'(g % 4), 1'b1,
             8'hD0 + 8'(g % 4), 4'b0001 << (g % 4));
      end
    end
    drive(4'h0, 4'h0, 1'b0, WD);
    idle("t2.end");

    // owner 2 stalled by fifo_full for 3 cycles after 2 beats
    drive(4'b0100, 4'h0, 1'b0, WD);
    idle("t3.arb");
    drive(4'b0100, 4'h0, 1'b0, WD);
    outs("t3.b0", 1'b1, 2'd2, 1'b1, 8'hD2, 4'b0100);
    drive(4'b0100, 4'h0, 1'b0, WD);
    outs("t3.b1", 1'b1, 2'd2, 1'b1, 8'hD2, 4'b0100);
    for (int s = 0; s < 3; s++) begin
      // requester 0 asks meanwhile and must be ignored
      drive(4'b0101, 4'h0, 1'b1, WD);
      outs($sformatf("t3.stall%0d", s), 1'b1, 2'd2, 1'b0, 8'h00, 4'b0000);
      chk($sformatf("t3.stall%0d.cnt", s), 32'(dut.r_beat_cnt), 32'd2);
    end
    drive(4'b0101, 4'h0, 1'b0, WD);
    outs("t3.b2", 1'b1, 2'd2, 1'b1, 8'hD2, 4'b0100);
    drive(4'b0101, 4'h0, 1'b0, WD);
    outs("t3.b3", 1'b1, 2'd2, 1'b1, 8'hD2, 4'b0100);
    drive(4'b0101, 4'h0, 1'b0, WD);
    idle("t3.end");

    // wrap-around grant to 0, which drops req after one beat
    drive(4'b0101, 4'h0, 1'b0, WD);
    outs("t4.b0", 1'b1, 2'd0, 1'b1, 8'hD0, 4'b0001);
    drive(4'b0100, 4'h0, 1'b0, WD);
    outs("t4.drop", 1'b1, 2'd0, 1'b0, 8'h00, 4'b0000);
    drive(4'b0100, 4'h0, 1'b0, WD);
    idle("t4.idle");
    chk("t4.cnt", 32'(dut.r_beat_cnt), 32'd1);
    drive(4'b0100, 4'h0, 1'b0, WD);
    outs("t4.next", 1'b1, 2'd2, 1'b1, 8'hD2, 4'b0100);
    drive(4'b0000, 4'h0, 1'b0, WD);
    outs("t4.rel", 1'b1, 2'd2, 1'b0, 8'h00, 4'b0000);
    drive(4'b0000, 4'h0, 1'b0, WD);
    idle("t4.end");

    // reset during the 2nd beat of owner 3
    drive(4'b1000, 4'h0, 1'b0, WD);
    idle("t5.arb");
    drive(4'b1000, 4'h0, 1'b0, WD);
    outs("t5.b0", 1'b1, 2'd3, 1'b1, 8'hD3, 4'b1000);
    drive(4'b1000, 4'h0, 1'b0, WD);
    outs("t5.b1", 1'b1, 2'd3, 1'b1, 8'hD3, 4'b1000);
    rst_n = 1'b0; #1;
    idle("t5.rst");
    chk("t5.rst.owner", 32'(owner), 32'd0);
    drive(4'b1000, 4'h0, 1'b0, WD);
    idle("t5.rsthold");
    chk("t5.rsthold.owner", 32'(owner), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; req = 4'b1001; #1;
    idle("t5.rel");
    drive(4'b1001, 4'h0, 1'b0, WD);
    outs("t5.first", 1'b1, 2'd0, 1'b1, 8'hD0, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter DW, default 8, data width, matching the FIFO data_in width.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum beats per grant (1..16).
REQ-004 SHALL have port clk  in  1  sole clock, rising-edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port req  in  NREQ  per-requester write request, held while data pending.
REQ-007 SHALL have port wdata  in  NREQ*DW  flattened requester data, requester i in bits [i*DW +: DW].
REQ-008 SHALL have port last  in  NREQ  per-requester end-of-burst marker, qualified by req.
REQ-009 SHALL have port ack  out  NREQ  one-hot beat-accepted strobe to the requester.
REQ-010 SHALL have port fifo_full  in  1  FIFO full flag.
REQ-011 SHALL have port fifo_wr  out  1  FIFO write enable (drives wr_in).
REQ-012 SHALL have port fifo_data  out  DW  FIFO write data (drives data_in).
REQ-013 SHALL have port owner  out  clog2(NREQ)  index of the current grantee.
REQ-014 SHALL have port busy  out  1  high while in GRANT.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-016 In IDLE with any req bit high, SHALL select the first requester at or after (last_owner+1) mod NREQ, wrapping, register it in owner and last_owner, and enter GRANT on the next edge; arbitration latency is 1 cycle.
REQ-017 In IDLE, fifo_wr and ack SHALL be 0.
REQ-018 In GRANT, fifo_wr SHALL equal req[owner] AND NOT fifo_full in the same cycle (combinational from registered owner); a beat is a cycle with fifo_wr=1.
REQ-019 fifo_data SHALL equal wdata[owner] when fifo_wr=1 and 0 otherwise.
REQ-020 ack SHALL be one-hot at bit owner exactly when fifo_wr=1, and all-zero otherwise.
REQ-021 A beat_cnt register SHALL clear on entry to GRANT and increment on each beat.
REQ-022 A beat with last[owner]=1, or a beat with beat_cnt = MAX_BURST-1, SHALL return the FSM to IDLE on the next edge.
REQ-023 While fifo_full=1 in GRANT, the block SHALL stall: no beat, no ack, beat_cnt and owner held, FSM stays in GRANT.
REQ-024 If req[owner] is 0 in GRANT, the grant SHALL be released (GRANT->IDLE) with no beat.
REQ-025 Requests from non-owners SHALL be ignored during GRANT and arbitrated only at the next IDLE.
REQ-026 After each burst, the FSM SHALL spend exactly one IDLE cycle before the next grant.
REQ-027 No requester SHALL wait more than NREQ grants (round-robin fairness).

Reset
REQ-028 On rst_n low, state SHALL go to IDLE, owner to 0, last_owner to NREQ-1, beat_cnt to 0, busy to 0, fifo_wr to 0, ack to 0, and fifo_data to 0, asynchronously.
REQ-029 Reset asserted mid-burst SHALL abort the burst; no fifo_wr SHALL occur while rst_n is low, and requester 0 SHALL have first priority after release.

Structure
REQ-030 Package fifo_arb_pkg SHALL hold the state encoding (IDLE=0, GRANT=1) and the default values of NREQ, DW and MAX_BURST.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req and last_owner; outputs valid and index); all other logic SHALL stay in fifo_wr_arb.

Verification
REQ-032 Reset, then req=0001 with wdata0=0xA1,0xA2 and last on the second beat -> owner=0 from cycle 2, fifo_wr on cycles 2-3 with data A1 then A2, IDLE on cycle 4.
REQ-033 req=1111 held with last=0 and MAX_BURST=4 -> grants in order 0,1,2,3,0, each 4 beats followed by 1 IDLE cycle.
REQ-034 Owner 2 mid-burst with fifo_full raised for 3 cycles -> fifo_wr=0 and ack=0 for those 3 cycles, beat_cnt unchanged, burst resumes and completes its remaining beats.
REQ-035 Owner drops req after 1 beat -> GRANT->IDLE with beat_cnt=1 and no further ack, next requester granted.
REQ-036 rst_n pulsed low during the 2nd beat of owner 3 -> fifo_wr=0 immediately, owner=0; after release with req=1001, requester 0 is granted first.
